multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using one shared ALU and one shared memory port.
- Waits on a memory ready handshake, with a watchdog that halts the core on a bus error.
- Sits between the instruction register (opcode/funct in), the datapath muxes and enables, and the unified memory interface.

---
 rtl/multicycle_pkg.sv | 73 +++++++
 rtl/multicycle_control_mem_watchdog.sv | 38 +++
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state, opcode/funct and datapath-select encodings shared by the
// multi-cycle MIPS controller and its memory watchdog.
package multicycle_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, EXC} state_e;

  typedef enum logic [2:0] {
    IC_RTYPE, IC_BRANCH, IC_JUMP, IC_IMM, IC_LOAD, IC_STORE, IC_UNKNOWN
  } instrClass_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_ALUOUT = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  function automatic instrClass_e classify(input logic [5:0] op);
    case (op)
      OP_RTYPE:                                  return IC_RTYPE;
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: return IC_BRANCH;
      OP_J, OP_JAL:                              return IC_JUMP;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: return IC_IMM;
      OP_LW:                                     return IC_LOAD;
      OP_SW:                                     return IC_STORE;
      default:                                   return IC_UNKNOWN;
    endcase
  endfunction

  function automatic logic knownFunct(input logic [5:0] fn);
    return fn inside {FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR, [FN_ADD:FN_NOR], FN_SLT, FN_SLTU};
  endfunction

endpackage

// File: rtl/multicycle_control_mem_watchdog.sv
// mc_mem_watchdog: counts memory wait cycles within a state and raises a sticky bus error
// when the access is still not ready once the count has reached MEM_TIMEOUT.
module mc_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned WAIT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic timeout,
  output logic busErr
);

  logic [WAIT_W-1:0] cntQ;
  logic              atLimit;

  assign atLimit = (cntQ == WAIT_W'(MEM_TIMEOUT));
  // A ready on the limit cycle is not a wait, so completion wins over the error.
  assign timeout = waiting && atLimit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ   <= '0;
      busErr <= 1'b0;
    end else begin
      if (clear) begin
        cntQ <= '0;
      end else if (waiting && !atLimit) begin
        cntQ <= cntQ + WAIT_W'(1);
      end
      if (timeout) begin
        busErr <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle MIPS core.
// Defining MULTICYCLE_EXC_EN routes unknown opcodes/functs through EXC and adds epc_write.
module multicycle_control #(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned FUNCT_W     = 6,
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned WAIT_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic               LuOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
`ifdef MULTICYCLE_EXC_EN
  output logic               epc_write,
`endif
  output logic               bus_err
);
  import multicycle_pkg::*;

  state_e      stateQ, stateD;
  instrClass_e iClass;
  logic [5:0]  op6, fn6;
  logic        jrOp, jalrOp, badInstr, waiting, timeout, stateChange;

  assign op6    = 6'(OpCode);
  assign fn6    = 6'(Funct);
  assign iClass = classify(op6);
  assign jrOp   = (fn6 == FN_JR);
  assign jalrOp = (fn6 == FN_JALR);
`ifdef MULTICYCLE_EXC_EN
  assign badInstr = (iClass == IC_UNKNOWN) || ((iClass == IC_RTYPE) && !knownFunct(fn6));
`else
  assign badInstr = (iClass == IC_UNKNOWN);
`endif
  assign waiting     = mem_req && !mem_ready;
  assign stateChange = (stateD != stateQ);

  mc_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .WAIT_W     (WAIT_W)
  ) uWatchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (stateChange),
    .waiting(waiting),
    .timeout(timeout),
    .busErr (bus_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= FETCH;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      FETCH:  if (timeout) stateD = HALT; else if (mem_ready) stateD = DECODE;
      DECODE: stateD = EXEC;
      EXEC: begin
        if (badInstr) begin
`ifdef MULTICYCLE_EXC_EN
          stateD = EXC;
`else
          stateD = FETCH;
`endif
        end else begin
          case (iClass)
            IC_RTYPE:           stateD = (jrOp || jalrOp) ? FETCH : WB;
            IC_IMM:             stateD = WB;
            IC_LOAD, IC_STORE:  stateD = MEM;
            default:            stateD = FETCH;
          endcase
        end
      end
      MEM: begin
        if (timeout)        stateD = HALT;
        else if (mem_ready) stateD = (iClass == IC_LOAD) ? WB : FETCH;
      end
      WB, EXC: stateD = FETCH;
      HALT:    stateD = HALT;
      default: stateD = FETCH;
    endcase
  end

  // Outputs decode the current state; everything but ExtOp is forced low while in reset.
  always_comb begin
    mem_req = 1'b0;  IorD = 1'b0;  MemRead = 1'b0;  MemWrite = 1'b0;
    IRWrite = 1'b0;  PCWrite = 1'b0;  PCWriteCond = 1'b0;  PCSource = PC_ALU;
    RegWrite = 1'b0;  RegDst = RD_RT;  MemtoReg = M2R_ALU;
    ALUSrcA = 1'b0;  ALUSrcB = 2'b00;  ALUOp = '0;  instr_done = 1'b0;
    ExtOp = 1'b1;  LuOp = 1'b0;
`ifdef MULTICYCLE_EXC_EN
    epc_write = 1'b0;
`endif
    if (rst_n) begin
      ExtOp = (op6 != OP_ANDI);
      LuOp  = (op6 == OP_LUI);
      unique case (stateQ)
        FETCH: begin
          mem_req = 1'b1;  MemRead = 1'b1;  ALUSrcB = 2'b01;
          IRWrite = mem_ready;  PCWrite = mem_ready;
        end
        DECODE: ALUSrcB = 2'b11;
        EXEC: begin
          ALUOp[ALUOP_W-1] = OpCode[0];
          if (badInstr) begin
`ifndef MULTICYCLE_EXC_EN
            instr_done = 1'b1;
`endif
          end else begin
            case (iClass)
              IC_RTYPE: begin
                ALUSrcA = 1'b1;  ALUOp[2:0] = ALU_FUNCT;
                if (jrOp || jalrOp) begin
                  PCWrite = 1'b1;  PCSource = PC_RS;  instr_done = 1'b1;
                end
                if (jalrOp) begin
                  RegWrite = 1'b1;  RegDst = RD_RD;  MemtoReg = M2R_PC;
                end
              end
              IC_BRANCH: begin
                ALUSrcA = 1'b1;  ALUOp[2:0] = ALU_SUB;
                PCWriteCond = 1'b1;  PCSource = PC_ALUOUT;  instr_done = 1'b1;
              end
              IC_JUMP: begin
                PCWrite = 1'b1;  PCSource = PC_JUMP;  instr_done = 1'b1;
                if (op6 == OP_JAL) begin
                  RegWrite = 1'b1;  RegDst = RD_RA;  MemtoReg = M2R_PC;
                end
              end
              IC_IMM: begin
                ALUSrcA = 1'b1;  ALUSrcB = 2'b10;
                case (op6)
                  OP_ANDI:          ALUOp[2:0] = ALU_AND;
                  OP_SLTI, OP_SLTIU: ALUOp[2:0] = ALU_SLT;
                  default:          ALUOp[2:0] = ALU_ADD;
                endcase
              end
              IC_LOAD, IC_STORE: begin
                ALUSrcA = 1'b1;  ALUSrcB = 2'b10;  ALUOp[2:0] = ALU_ADD;
              end
              default: ;
            endcase
          end
        end
        MEM: begin
          mem_req  = 1'b1;  IorD = 1'b1;
          MemRead  = (iClass == IC_LOAD);
          MemWrite = (iClass == IC_STORE);
          instr_done = mem_ready && (iClass == IC_STORE);
        end
        WB: begin
          RegWrite = 1'b1;  instr_done = 1'b1;
          RegDst   = (iClass == IC_RTYPE) ? RD_RD : RD_RT;
          MemtoReg = (iClass == IC_LOAD) ? M2R_MDR : M2R_ALU;
        end
        EXC: begin
          PCWrite = 1'b1;  PCSource = PC_ALUOUT;
`ifdef MULTICYCLE_EXC_EN
          epc_write = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized instruction sequences checked cycle by cycle
// against a phase-level reference model of the controller.
module tb_multicycle_control;

  logic       clk, rst_n, mem_ready;
  logic [5:0] OpCode, Funct;
  logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite;
  logic       ALUSrcA, ExtOp, LuOp, instr_done, bus_err;
  logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcB;
  logic [3:0] ALUOp;

  int checks = 0;
  int errors = 0;

  typedef enum int {PH_R, PH_F, PH_D, PH_E, PH_M, PH_W, PH_H} phase_e;

  logic [5:0] opPool [16] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                              6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b};
  logic [5:0] fnPool [11] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
                              6'h24, 6'h25, 6'h2a};

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .LuOp(LuOp), .ALUOp(ALUOp), .instr_done(instr_done),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector for one cycle of an instruction in a given phase.
  function automatic logic [24:0] expVec(input phase_e ph, input logic [5:0] op,
                                         input logic [5:0] fn, input logic rdy, input logic be);
    logic req, rd, wr, iord, irw, pcw, pcwc, regw, srcA, done, ext, lu;
    logic [1:0] pcSrc, regDst, m2r, srcB;
    logic [3:0] aluOp;
    logic isR, isBr, isJ, isImm, isLw, isSw;
    isR   = (op == 6'h00);
    isBr  = op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
    isJ   = op inside {6'h02, 6'h03};
    isImm = op inside {[6'h08:6'h0c], 6'h0f};
    isLw  = (op == 6'h23);
    isSw  = (op == 6'h2b);
    {req, rd, wr, iord, irw, pcw, pcwc, regw, srcA, done} = '0;
    {pcSrc, regDst, m2r, srcB} = '0;
    aluOp = 4'd0;
    ext = (op != 6'h0c);
    lu  = (op == 6'h0f);
    case (ph)
      PH_R: begin ext = 1'b1; lu = 1'b0; end
      PH_F: begin req = 1; rd = 1; srcB = 2'b01; irw = rdy; pcw = rdy; end
      PH_D: srcB = 2'b11;
      PH_E: begin
        aluOp[3] = op[0];
        if (isR) begin
          srcA = 1; aluOp[2:0] = 3'b010;
          if (fn == 6'h08 || fn == 6'h09) begin pcw = 1; pcSrc = 2'b10; done = 1; end
          if (fn == 6'h09) begin regw = 1; regDst = 2'b01; m2r = 2'b10; end
        end else if (isBr) begin
          srcA = 1; aluOp[2:0] = 3'b001; pcwc = 1; pcSrc = 2'b11; done = 1;
        end else if (isJ) begin
          pcw = 1; pcSrc = 2'b01; done = 1;
          if (op == 6'h03) begin regw = 1; regDst = 2'b10; m2r = 2'b10; end
        end else if (isImm) begin
          srcA = 1; srcB = 2'b10;
          aluOp[2:0] = (op == 6'h0c) ? 3'b100 : (op inside {6'h0a, 6'h0b}) ? 3'b101 : 3'b000;
        end else if (isLw || isSw) begin
          srcA = 1; srcB = 2'b10;
        end else begin
          done = 1;
        end
      end
      PH_M: begin req = 1; iord = 1; rd = isLw; wr = isSw; done = isSw && rdy; end
      PH_W: begin regw = 1; done = 1; regDst = isR ? 2'b01 : 2'b00; m2r = isLw ? 2'b01 : 2'b00; end
      default: ;
    endcase
    return {req, rd, wr, iord, irw, pcw, pcwc, pcSrc, regw, regDst, m2r, srcA, srcB,
            ext, lu, aluOp, done, be};
  endfunction

  // Called at posedge+1; drives mem_ready, compares at negedge, returns at next posedge+1.
  task automatic step(input phase_e ph, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic be, input string tag);
    logic [24:0] want, obs;
    mem_ready = rdy;
    @(negedge clk);
    want = expVec(ph, op, fn, rdy, be);
    obs  = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
            RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuOp, ALUOp, instr_done,
            bus_err};
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s op=%h fn=%h observed=%h expected=%h", tag, op, fn, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int fd,
                          input int md, input string tag);
    OpCode = op;
    Funct  = fn;
    for (int i = 0; i <= fd; i++) step(PH_F, op, fn, (i == fd), 1'b0, {tag, "/fetch"});
    step(PH_D, op, fn, 1'($urandom_range(0, 1)), 1'b0, {tag, "/decode"});
    step(PH_E, op, fn, 1'($urandom_range(0, 1)), 1'b0, {tag, "/exec"});
    if (op == 6'h23 || op == 6'h2b)
      for (int i = 0; i <= md; i++) step(PH_M, op, fn, (i == md), 1'b0, {tag, "/mem"});
    if (op == 6'h23 || (op inside {[6'h08:6'h0c], 6'h0f}) ||
        (op == 6'h00 && !(fn inside {6'h08, 6'h09})))
      step(PH_W, op, fn, 1'($urandom_range(0, 1)), 1'b0, {tag, "/wb"});
  endtask

  initial begin
    logic [5:0] op, fn;
    rst_n = 1'b0; mem_ready = 1'b0; OpCode = 6'h0f; Funct = 6'h00;
    @(posedge clk);
    #1;
    step(PH_R, 6'h0f, 6'h00, 1'b0, 1'b0, "reset");
    rst_n = 1'b1;

    runInstr(6'h00, 6'h20, 0, 0, "add");
    runInstr(6'h23, 6'h00, 3, 2, "lw");
    runInstr(6'h04, 6'h00, 0, 0, "beq");
    runInstr(6'h03, 6'h00, 0, 0, "jal");
    runInstr(6'h00, 6'h09, 1, 0, "jalr");
    runInstr(6'h0c, 6'h00, 0, 0, "andi");
    runInstr(6'h0d, 6'h00, 0, 0, "unknown");
    runInstr(6'h2b, 6'h00, 0, 15, "sw-ready-at-limit");
    runInstr(6'h00, 6'h02, 15, 0, "srl-fetch-at-limit");

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : opPool[$urandom_range(0, 15)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fnPool[$urandom_range(0, 10)];
      runInstr(op, fn, $urandom_range(0, 4), $urandom_range(0, 4), "random");
    end

    // Reset in the middle of a store access.
    OpCode = 6'h2b; Funct = 6'h00;
    step(PH_F, 6'h2b, 6'h00, 1'b1, 1'b0, "rstmid/fetch");
    step(PH_D, 6'h2b, 6'h00, 1'b0, 1'b0, "rstmid/decode");
    step(PH_E, 6'h2b, 6'h00, 1'b0, 1'b0, "rstmid/exec");
    step(PH_M, 6'h2b, 6'h00, 1'b0, 1'b0, "rstmid/mem");
    step(PH_M, 6'h2b, 6'h00, 1'b0, 1'b0, "rstmid/mem");
    rst_n = 1'b0;
    #1;
    checks++;
    assert (mem_req === 1'b0) else begin
      errors++;
      $error("FAIL rstmid/req-drop observed=%b expected=%b", mem_req, 1'b0);
    end
    step(PH_R, 6'h2b, 6'h00, 1'b0, 1'b0, "rstmid/in-reset");
    rst_n = 1'b1;
    step(PH_F, 6'h2b, 6'h00, 1'b0, 1'b0, "rstmid/after");
    runInstr(6'h00, 6'h22, 1, 0, "sub-after-reset");

    // Store that never completes: watchdog trips and the core halts.
    OpCode = 6'h2b; Funct = 6'h00;
    step(PH_F, 6'h2b, 6'h00, 1'b1, 1'b0, "timeout/fetch");
    step(PH_D, 6'h2b, 6'h00, 1'b0, 1'b0, "timeout/decode");
    step(PH_E, 6'h2b, 6'h00, 1'b0, 1'b0, "timeout/exec");
    for (int i = 0; i < 16; i++) step(PH_M, 6'h2b, 6'h00, 1'b0, 1'b0, "timeout/mem-wait");
    for (int i = 0; i < 4; i++)
      step(PH_H, 6'h2b, 6'h00, 1'($urandom_range(0, 1)), 1'b1, "timeout/halt");
    rst_n = 1'b0;
    step(PH_R, 6'h2b, 6'h00, 1'b0, 1'b0, "timeout/in-reset");
    rst_n = 1'b1;
    runInstr(6'h00, 6'h20, 0, 0, "add-after-halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
